// File: rtl/div_defs.sv
// Shared definitions for the multi-cycle signed divider.
package div_defs;

  localparam int DIV_WIDTH = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step_32.sv
// One restoring-division step on the {R,Q} pair.
module div_step_32
  import div_defs::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] r_o,
  output logic [W-1:0] q_o
);

  logic [W:0]   sh;
  logic         geq;
  logic [W-1:0] diff;

  always_comb begin
    sh   = {r_i, q_i[W-1]};
    geq  = (sh >= {1'b0, dvs_i});
    // When geq holds the difference is below the divisor, so W bits suffice.
    diff = sh[W-1:0] - dvs_i;
    if (geq) begin
      r_o = diff;
      q_o = {q_i[W-2:0], 1'b1};
    end else begin
      r_o = sh[W-1:0];
      q_o = {q_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_32_bit.sv
// Signed multi-cycle restoring divider: LO = quotient, HI = remainder.
module div_32_bit
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic sgn_q_q, sgn_q_d;
  logic sgn_r_q, sgn_r_d;
  logic zero_q, zero_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic dz_q, dz_d;

  logic [WIDTH-1:0] r_step, q_step;
  logic [WIDTH-1:0] neg_a_in, neg_b_in;
  logic [WIDTH-1:0] neg_a, neg_b;
  logic [WIDTH-1:0] abs_num, abs_dvs;

  div_step_32 #(.W(WIDTH)) u_step (
    .r_i  (r_q),
    .q_i  (q_q),
    .dvs_i(dvs_q),
    .r_o  (r_step),
    .q_o  (q_step)
  );

  // The two negators serve operand entry in IDLE and sign fix-up in FIX.
  always_comb begin
    neg_a_in = (state_q == S_FIX) ? q_q : dividend;
    neg_b_in = (state_q == S_FIX) ? r_q : divisor;
    neg_a    = ~neg_a_in + WIDTH'(1);
    neg_b    = ~neg_b_in + WIDTH'(1);
    abs_num  = dividend[WIDTH-1] ? neg_a : dividend;
    abs_dvs  = divisor[WIDTH-1] ? neg_b : divisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    num_d   = num_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgn_r_d = dividend[WIDTH-1];
          q_d     = abs_num;
          r_d     = '0;
          dvs_d   = abs_dvs;
          num_d   = dividend;
          zero_d  = (divisor == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (zero_q) begin
          quo_d = WIDTH'(DIV_ZERO_Q);
          rem_d = num_q;
          dz_d  = 1'b1;
        end else begin
          quo_d = sgn_q_q ? neg_a : q_q;
          rem_d = sgn_r_q ? neg_b : r_q;
          dz_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      num_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      num_q   <= num_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule
